// File: rtl/press_counter_hex.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | press_counter_hex                                                          |
// | Debounced inc/dec buttons drive an 8-bit wrapping count shown as two hex   |
// | nibbles.                                                                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module press_counter_hex #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch_Inc,
    input  logic       i_Switch_Dec,
    output logic [3:0] o_Upper_Nibble,
    output logic [3:0] o_Lower_Nibble,
    output logic       o_Count_Changed
);

    localparam logic [19:0] c_LIMIT_M1 = 20'(DEBOUNCE_LIMIT - 1);

    logic [1:0] w_raw;
    logic [1:0] w_event;
    logic [7:0] r_count;
    logic       r_changed;
    logic [7:0] w_count_next;
    logic       w_modified;

    // Bit 0 is the increment button, bit 1 the decrement button.
    assign w_raw = {i_Switch_Dec, i_Switch_Inc};

    for (genvar g = 0; g < 2; g++) begin : g_sw
        logic        r_s1;
        logic        r_s2;
        logic        r_stable;
        logic        r_stable_d;
        logic        r_event;
        logic [19:0] r_db_cnt;

        always_ff @(posedge i_Clk) begin
            if (i_Rst) begin
                r_s1       <= 1'b0;
                r_s2       <= 1'b0;
                r_stable   <= 1'b0;
                r_stable_d <= 1'b0;
                r_event    <= 1'b0;
                r_db_cnt   <= 20'd0;
            end else begin
                r_s1       <= w_raw[g];
                r_s2       <= r_s1;
                r_stable_d <= r_stable;
                r_event    <= r_stable & ~r_stable_d;
                // Any cycle agreeing with the stable level restarts the run.
                if (r_s2 == r_stable) begin
                    r_db_cnt <= 20'd0;
                end else if (r_db_cnt == c_LIMIT_M1) begin
                    r_stable <= r_s2;
                    r_db_cnt <= 20'd0;
                end else begin
                    r_db_cnt <= r_db_cnt + 20'd1;
                end
            end
        end

        assign w_event[g] = r_event;
    end

    always_comb begin
        w_count_next = r_count;
        w_modified   = 1'b0;
        case (w_event)
            2'b01: begin
                w_count_next = r_count + 8'd1;
                w_modified   = 1'b1;
            end
            2'b10: begin
                w_count_next = r_count - 8'd1;
                w_modified   = 1'b1;
            end
            default: begin
                w_count_next = r_count;
                w_modified   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_count   <= 8'd0;
            r_changed <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            r_changed <= w_modified;
        end
    end

    assign o_Upper_Nibble  = r_count[7:4];
    assign o_Lower_Nibble  = r_count[3:0];
    assign o_Count_Changed = r_changed;

endmodule
`default_nettype wire
